serial_controller: RTL and testbench

- Memory-mapped UART responder behind the MMU's serial window (data port and status port); the peer of the MMU-side serial signals.
- Serialises CPU write bytes onto uart_txd (8N1).
- Deserialises uart_rxd into a one-byte receive buffer and reports send/receive status for CPU polling.
- Sits between the MMU and the board UART pins, in the single system clock domain.

---
 rtl/serial_controller_pkg.sv | 21 ++
 rtl/serial_controller_rx.sv | 81 ++++++++
 rtl/serial_controller.sv | 117 +++++++++++
 tb/tb_serial_controller.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_controller_pkg.sv
// serial_controller_pkg: shared constants and UART state encodings for the serial window
//   ENABLE/DISABLE       block enable levels
//   MEM_WRITE/MEM_READ   readWrite strobe levels
//   uart_state_t         2-bit encoding shared by the TX and RX FSMs
package serial_controller_pkg;

    localparam logic ENABLE    = 1'b1;
    localparam logic DISABLE   = 1'b0;
    localparam logic MEM_WRITE = 1'b1;
    localparam logic MEM_READ  = 1'b0;

    localparam int DEFAULT_CLKS_PER_BIT = 96;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/serial_controller_rx.sv
// uart_rx_core: 8N1 receiver with 2-flop input synchroniser
//   clk, rst   system clock, async active-low reset
//   i_rxd      raw serial input
//   o_byte     last assembled byte (LSB first)
//   o_valid    one-cycle pulse when a frame with a good stop bit completes
module uart_rx_core
    import serial_controller_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int CNT_W        = 8
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rxd,
    output logic [7:0] o_byte,
    output logic       o_valid
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             r_sync1, r_sync2;
    uart_state_t      r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]       r_idx, w_idx_nxt;
    logic [7:0]       r_shift, w_shift_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_state <= UART_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            r_sync1 <= i_rxd;
            r_sync2 <= r_sync1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // START waits half a bit so every later sample lands one full bit apart at bit centres;
    // STOP drops straight back to IDLE after its centre sample to catch a back-to-back start bit.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        o_valid     = 1'b0;
        case (r_state)
            UART_IDLE: begin
                w_cnt_nxt = '0;
                if (!r_sync2) w_state_nxt = UART_START;
            end
            UART_START: if (r_cnt == MID) begin
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
                w_state_nxt = r_sync2 ? UART_IDLE : UART_DATA;
            end
            UART_DATA: if (r_cnt == LAST) begin
                w_cnt_nxt   = '0;
                w_shift_nxt = {r_sync2, r_shift[7:1]};
                w_idx_nxt   = r_idx + 1'b1;
                if (r_idx == 3'd7) w_state_nxt = UART_STOP;
            end
            UART_STOP: if (r_cnt == LAST) begin
                w_cnt_nxt   = '0;
                o_valid     = r_sync2;
                w_state_nxt = UART_IDLE;
            end
            default: w_state_nxt = UART_IDLE;
        endcase
    end

    assign o_byte = r_shift;

endmodule

// File: rtl/serial_controller.sv
// serial_controller: memory-mapped 8N1 UART responder for the MMU serial window
//   clk, rst                  system clock, async active-low reset
//   serial_enable_i           block enable (strobes ignored when low)
//   serial_readWrite_i        1 = write, 0 = read
//   serial_dataWrite_i        byte to transmit
//   serial_fetch_data_i       CPU reading the data port
//   serial_dataRead_o         receive buffer
//   serial_sendComplete_o     transmitter idle
//   serial_receiveComplete_o  unread byte in buffer
//   uart_rxd, uart_txd        UART pins
module serial_controller
    import serial_controller_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int CNT_W        = 8
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_enable_i,
    input  logic       serial_readWrite_i,
    input  logic [7:0] serial_dataWrite_i,
    input  logic       serial_fetch_data_i,
    output logic [7:0] serial_dataRead_o,
    output logic       serial_sendComplete_o,
    output logic       serial_receiveComplete_o,
    input  logic       uart_rxd,
    output logic       uart_txd
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic             r_rw_q, r_fetch_q;
    logic             w_wr_pulse, w_rd_pulse;
    uart_state_t      r_tx_state, w_tx_state_nxt;
    logic [CNT_W-1:0] r_tx_cnt, w_tx_cnt_nxt;
    logic [2:0]       r_tx_idx, w_tx_idx_nxt;
    logic [7:0]       r_tx_data, w_tx_data_nxt;
    logic             r_txd, w_txd_nxt, w_tx_last;
    logic [7:0]       r_buf, w_rx_byte;
    logic             r_flag, w_rx_valid;

    // The MMU holds its strobes across stalls, so only the rising edge counts as an access.
    assign w_wr_pulse = (serial_enable_i == ENABLE) && (serial_readWrite_i == MEM_WRITE) && (r_rw_q != MEM_WRITE);
    assign w_rd_pulse = (serial_enable_i != DISABLE) && serial_fetch_data_i && !r_fetch_q;

    always_comb begin
        w_tx_last      = r_tx_cnt == LAST;
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = w_tx_last ? '0 : r_tx_cnt + 1'b1;
        w_tx_idx_nxt   = r_tx_idx;
        w_tx_data_nxt  = r_tx_data;
        case (r_tx_state)
            UART_IDLE: begin
                w_tx_cnt_nxt = '0;
                if (w_wr_pulse) begin
                    w_tx_state_nxt = UART_START;
                    w_tx_data_nxt  = serial_dataWrite_i;
                end
            end
            UART_START: if (w_tx_last) begin
                w_tx_state_nxt = UART_DATA;
                w_tx_idx_nxt   = '0;
            end
            UART_DATA: if (w_tx_last) begin
                w_tx_idx_nxt = r_tx_idx + 1'b1;
                if (r_tx_idx == 3'd7) w_tx_state_nxt = UART_STOP;
            end
            UART_STOP: if (w_tx_last) w_tx_state_nxt = UART_IDLE;
            default: w_tx_state_nxt = UART_IDLE;
        endcase
        // txd is registered from the next state so the pin never glitches on state decode.
        w_txd_nxt = w_tx_state_nxt == UART_START ? 1'b0 :
                    w_tx_state_nxt == UART_DATA  ? w_tx_data_nxt[w_tx_idx_nxt] : 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rw_q     <= MEM_READ;
            r_fetch_q  <= 1'b0;
            r_tx_state <= UART_IDLE;
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx_data  <= '0;
            r_txd      <= 1'b1;
            r_buf      <= '0;
            r_flag     <= 1'b0;
        end else begin
            r_rw_q     <= serial_readWrite_i;
            r_fetch_q  <= serial_fetch_data_i;
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_idx   <= w_tx_idx_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_txd      <= w_txd_nxt;
            r_buf      <= w_rx_valid ? w_rx_byte : r_buf;
            // A new byte wins over a same-cycle read; overrun silently overwrites.
            r_flag     <= w_rx_valid || (r_flag && !w_rd_pulse);
        end
    end

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .CNT_W       (CNT_W)
    ) u_rx (
        .clk    (clk),
        .rst    (rst),
        .i_rxd  (uart_rxd),
        .o_byte (w_rx_byte),
        .o_valid(w_rx_valid)
    );

    assign uart_txd                 = r_txd;
    assign serial_sendComplete_o    = r_tx_state == UART_IDLE;
    assign serial_receiveComplete_o = r_flag;
    assign serial_dataRead_o        = r_buf;

endmodule

// File: tb/tb_serial_controller.sv
// tb_serial_controller: random + directed checks of serial_controller against a frame-level model
module tb_serial_controller;

    localparam int CPB    = 4;
    localparam int TX_LEN = 10 * CPB;
    // rxd low seen at edge P0: 2 synchroniser edges, half a bit to the start centre, 9 bits to the stop centre
    localparam int RX_LAT = 2 + CPB / 2 + 9 * CPB;

    typedef struct {
        int         c;
        logic [7:0] b;
        logic       ok;
    } rx_ev_t;

    logic       clk = 1'b0, rst = 1'b0, en = 1'b0, rw = 1'b0, fe = 1'b0, rxd = 1'b1;
    logic [7:0] dw = 8'h00;
    logic [7:0] dr;
    logic       sc, rc, txd;

    int checks = 0, errors = 0;

    serial_controller #(.CLKS_PER_BIT(CPB), .CNT_W(8)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .serial_enable_i         (en),
        .serial_readWrite_i      (rw),
        .serial_dataWrite_i      (dw),
        .serial_fetch_data_i     (fe),
        .serial_dataRead_o       (dr),
        .serial_sendComplete_o   (sc),
        .serial_receiveComplete_o(rc),
        .uart_rxd                (rxd),
        .uart_txd                (txd)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Frame-level model: TX is "cycles since accept" into a 10-bit frame, RX is a schedule of byte arrivals.
    int         cyc = 0, m_k = 0, last_sched = 0;
    logic [9:0] m_frame = 10'h3FF;
    logic       m_rw_q = 1'b0, m_fe_q = 1'b0, m_flag = 1'b0, m_wr, m_rd, m_got;
    logic [7:0] m_buf = 8'h00;
    rx_ev_t     sched[$];
    rx_ev_t     m_ev;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_k    = 0;
            m_rw_q = 1'b0;
            m_fe_q = 1'b0;
            m_flag = 1'b0;
            m_buf  = 8'h00;
            sched.delete();
        end else begin
            cyc++;
            m_wr   = en && rw && !m_rw_q;
            m_rd   = en && fe && !m_fe_q;
            m_rw_q = rw;
            m_fe_q = fe;
            if (m_k == 0) begin
                if (m_wr) begin
                    m_k     = 1;
                    m_frame = {1'b1, dw, 1'b0};
                end
            end else
                m_k = (m_k == TX_LEN) ? 0 : m_k + 1;
            m_got = 1'b0;
            if (sched.size() > 0 && sched[0].c == cyc) begin
                m_ev = sched.pop_front();
                if (m_ev.ok) begin
                    m_buf  = m_ev.b;
                    m_flag = 1'b1;
                    m_got  = 1'b1;
                end
            end
            if (!m_got && m_rd) m_flag = 1'b0;
        end
    end

    always @(posedge clk) begin
        #2;
        chk("txd", txd, m_k == 0 ? 1'b1 : m_frame[(m_k - 1) / CPB]);
        chk("sendComplete", sc, m_k == 0);
        chk("receiveComplete", rc, m_flag);
        chk("dataRead", dr, m_buf);
    end

    task automatic cpu_write(input logic [7:0] d, input int hold);
        @(negedge clk);
        en = 1'b1;
        dw = d;
        rw = 1'b1;
        repeat (hold) @(negedge clk);
        rw = 1'b0;
    endtask

    task automatic cpu_fetch(input int hold);
        @(negedge clk);
        en = 1'b1;
        fe = 1'b1;
        repeat (hold) @(negedge clk);
        fe = 1'b0;
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop, input int gap);
        @(negedge clk);
        rxd = 1'b0;
        last_sched = cyc + 1 + RX_LAT;
        sched.push_back('{last_sched, b, stop});
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            rxd = b[i];
        end
        repeat (CPB) @(negedge clk);
        rxd = stop;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic rx_glitch();
        @(negedge clk);
        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    logic [39:0] txw;
    int          lowcnt;
    logic [9:0]  a5_frame;

    initial begin
        en = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_txd", txd, 1'b1);
        chk("reset_sendComplete", sc, 1'b1);
        chk("reset_receiveComplete", rc, 1'b0);
        chk("reset_dataRead", dr, 8'h00);

        // A5 held 3 cycles, 3C attempted mid-frame
        a5_frame = {1'b1, 8'hA5, 1'b0};
        @(negedge clk);
        dw = 8'hA5;
        rw = 1'b1;
        lowcnt = 0;
        for (int i = 0; i < 44; i++) begin
            @(posedge clk);
            #2;
            if (i < 40) txw[i] = txd;
            if (!sc) lowcnt++;
            if (i == 2) rw = 1'b0;
            if (i == 15) begin
                dw = 8'h3C;
                rw = 1'b1;
            end
            if (i == 17) rw = 1'b0;
        end
        for (int b = 0; b < 10; b++)
            chk($sformatf("a5_bit%0d", b), txw[4*b +: 4], {4{a5_frame[b]}});
        chk("a5_send_low_cycles", lowcnt, 40);
        chk("a5_idle_txd", txd, 1'b1);
        cpu_write(8'h3C, 1);
        repeat (TX_LEN + 5) @(negedge clk);
        chk("3c_done", sc, 1'b1);

        // receive 41, single read held 5 cycles
        rx_frame(8'h41, 1'b1, 3);
        chk("rx41_flag", rc, 1'b1);
        chk("rx41_data", dr, 8'h41);
        cpu_fetch(5);
        repeat (2) @(negedge clk);
        chk("rx41_flag_cleared", rc, 1'b0);
        chk("rx41_data_kept", dr, 8'h41);

        // overrun, framing error, glitch
        rx_frame(8'h11, 1'b1, 3);
        rx_frame(8'h22, 1'b1, 3);
        chk("overrun_data", dr, 8'h22);
        chk("overrun_flag", rc, 1'b1);
        rx_frame(8'h99, 1'b0, 10);
        chk("framing_data", dr, 8'h22);
        chk("framing_flag", rc, 1'b1);
        rx_glitch();
        chk("glitch_data", dr, 8'h22);
        cpu_fetch(1);
        repeat (2) @(negedge clk);
        chk("read_clears", rc, 1'b0);
        rx_glitch();
        chk("glitch_flag", rc, 1'b0);

        // read strobe rising on the same edge a byte lands
        fork
            rx_frame(8'h5A, 1'b1, 3);
            begin
                repeat (2) @(negedge clk);
                for (int i = 0; i < 200 && cyc != last_sched - 1; i++) @(negedge clk);
                chk("coincide_align", cyc == last_sched - 1, 1'b1);
                fe = 1'b1;
                repeat (3) @(negedge clk);
                fe = 1'b0;
            end
        join
        repeat (2) @(negedge clk);
        chk("coincide_flag", rc, 1'b1);
        chk("coincide_data", dr, 8'h5A);

        // reset mid-TX and mid-RX
        fork
            cpu_write(8'h55, 2);
            rx_frame(8'h66, 1'b1, 3);
            begin
                repeat (16) @(negedge clk);
                chk("pre_reset_busy", sc, 1'b0);
                rst = 1'b0;
                #1;
                chk("rst_txd", txd, 1'b1);
                chk("rst_sendComplete", sc, 1'b1);
                chk("rst_receiveComplete", rc, 1'b0);
                chk("rst_dataRead", dr, 8'h00);
            end
        join
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rx_frame(8'hC3, 1'b1, 3);
        chk("post_reset_flag", rc, 1'b1);
        chk("post_reset_data", dr, 8'hC3);
        cpu_fetch(1);

        // random full-duplex traffic
        fork
            begin
                int op;
                for (int n = 0; n < 250; n++) begin
                    op = $urandom_range(0, 9);
                    if (op < 4) begin
                        en = 1'b1;
                        dw = 8'($urandom);
                        rw = 1'b1;
                        repeat ($urandom_range(1, 4)) @(negedge clk);
                        rw = 1'b0;
                    end else if (op < 7) begin
                        en = 1'b1;
                        fe = 1'b1;
                        repeat ($urandom_range(1, 5)) @(negedge clk);
                        fe = 1'b0;
                    end else if (op == 7) begin
                        en = 1'b0;
                        rw = 1'($urandom_range(0, 1));
                        fe = 1'($urandom_range(0, 1));
                        repeat (2) @(negedge clk);
                        rw = 1'b0;
                        fe = 1'b0;
                        en = 1'b1;
                    end
                    repeat ($urandom_range(1, 12)) @(negedge clk);
                end
            end
            begin
                int kind;
                for (int n = 0; n < 24; n++) begin
                    kind = $urandom_range(0, 9);
                    if (kind == 0) rx_glitch();
                    else if (kind == 1) rx_frame(8'($urandom), 1'b0, 10);
                    else rx_frame(8'($urandom), 1'b1, $urandom_range(1, 6));
                end
            end
        join
        repeat (TX_LEN + RX_LAT) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
